// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_unit_pkg
// Brief  : Shared definitions for the instruction fetch unit: fetch state
//          encodings, default reset PC and the canonical NOP encoding.
// Rev    : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // Fetch sequencing states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pcplusfour.sv
`default_nettype none
// ============================================================================
// Module : pcplusfour
// Brief  : Sequential next-PC adder; result wraps modulo 2^XLEN.
// Rev    : 1.0  initial release
// ============================================================================
module pcplusfour #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Plain modular increment, carry out of the top bit is dropped
    assign pc_plus4 = pc + XLEN'(4);

endmodule : pcplusfour
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_unit
// Brief  : Owns the architectural PC, runs req/gnt/rvalid instruction fetch
//          and presents {pc, instr, pc+4} to decode. Redirects are buffered
//          and applied when the next request starts; any fetch or held
//          instruction overtaken by a redirect is discarded.
// Rev    : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pcplus4,
    output logic            misalign_err
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_plus4;
    logic            pend_v, pend_v_nxt;
    logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
    logic            if_valid_nxt;
    logic [XLEN-1:0] if_pc_nxt, if_instr_nxt, if_pcplus4_nxt;
    logic            misalign_nxt;
    logic            kill;
    logic            tgt_misaligned;

    pcplusfour #(
        .XLEN (XLEN)
    ) u_pcplusfour (
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // A pending or arriving redirect invalidates whatever fetch is in flight
    assign kill           = pend_v | redirect_valid;
    assign tgt_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    // The request address is the PC itself, so it cannot move while waiting for gnt
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    // Next-state, next-PC and decode-output selection
    always_comb begin
        logic enter_req;
        state_nxt      = state;
        pc_nxt         = pc;
        pend_v_nxt     = pend_v;
        pend_tgt_nxt   = pend_tgt;
        if_valid_nxt   = if_valid;
        if_pc_nxt      = if_pc;
        if_instr_nxt   = if_instr;
        if_pcplus4_nxt = if_pcplus4;
        misalign_nxt   = misalign_err;
        enter_req      = 1'b0;

        // Latest redirect wins
        if (redirect_valid) begin
            pend_v_nxt   = 1'b1;
            pend_tgt_nxt = redirect_target;
        end

        case (state)
            ST_IDLE: begin
                enter_req = 1'b1;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        enter_req = 1'b1;
                    end else begin
                        if_valid_nxt   = 1'b1;
                        if_pc_nxt      = pc;
                        if_instr_nxt   = imem_rdata;
                        if_pcplus4_nxt = pc_plus4;
                        pc_nxt         = pc_plus4;
                        state_nxt      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A redirect drops the held instruction even while decode stalls
                if (kill || !stall) begin
                    if_valid_nxt = 1'b0;
                    enter_req    = 1'b1;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase

        // Starting a new request is the single point where a redirect lands
        if (enter_req) begin
            state_nxt = ST_REQ;
            if (kill) begin
                pc_nxt     = redirect_valid ? redirect_target : pend_tgt;
                pend_v_nxt = 1'b0;
            end
        end

        // A misaligned target stops fetch until reset
        if (tgt_misaligned && (state != ST_HALT)) begin
            state_nxt    = ST_HALT;
            misalign_nxt = 1'b1;
            if_valid_nxt = 1'b0;
            pend_v_nxt   = 1'b0;
        end
    end

    // State, PC, redirect buffer and decode output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            pend_v       <= 1'b0;
            pend_tgt     <= '0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= XLEN'(NOP_INSTR);
            if_pcplus4   <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            pend_v       <= pend_v_nxt;
            pend_tgt     <= pend_tgt_nxt;
            if_valid     <= if_valid_nxt;
            if_pc        <= if_pc_nxt;
            if_instr     <= if_instr_nxt;
            if_pcplus4   <= if_pcplus4_nxt;
            misalign_err <= misalign_nxt;
        end
    end

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_fetch_unit
// Brief  : Self-checking bench for pc_fetch_unit: directed scenarios with
//          literal expectations followed by randomized traffic, all checked
//          every cycle against a behavioural model of the fetch rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    // model phases
    localparam int PH_BOOT  = 0;
    localparam int PH_ASK   = 1;
    localparam int PH_AWAIT = 2;
    localparam int PH_SHOW  = 3;
    localparam int PH_DEAD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pcplus4;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;

    // memory configuration, written only by the main process
    int gnt_pct  = 100;
    int hold_cfg = 0;

    pc_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_pcplus4      (if_pcplus4),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 + (a << 18);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- one-cycle-latency memory with grant back-pressure ----
    logic [31:0] gnt_addr = 32'h0;
    int          hold_cnt = 0;
    bit          in_req   = 1'b0;

    always @(posedge clk) begin
        #2;
        imem_rvalid = imem_gnt;
        imem_rdata  = imem_gnt ? mem_word(gnt_addr) : $urandom();
        if (imem_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                hold_cnt = hold_cfg;
            end
            if (hold_cnt > 0) begin
                imem_gnt = 1'b0;
                hold_cnt--;
            end else begin
                imem_gnt = ($urandom_range(0, 99) < gnt_pct);
            end
            if (imem_gnt) begin
                gnt_addr = imem_addr;
                in_req   = 1'b0;
            end
        end else begin
            in_req   = 1'b0;
            imem_gnt = 1'b0;
        end
    end

    // ---------------- behavioural model -----------------------------------
    int          m_phase;
    logic [31:0] m_pc, m_ptgt, m_ipc, m_instr, m_ip4;
    bit          m_pend, m_vld, m_err, m_fresh;

    task automatic begin_fetch();
        if (m_pend) begin
            m_pc   = m_ptgt;
            m_pend = 1'b0;
        end
        m_phase = PH_ASK;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_phase = PH_BOOT; m_pc = RST_PC; m_pend = 0; m_ptgt = 0;
            m_vld = 0; m_ipc = 0; m_instr = NOP; m_ip4 = 0; m_err = 0; m_fresh = 1;
            return;
        end
        if (m_phase == PH_DEAD) return;
        if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            m_phase = PH_DEAD;
            m_err   = 1'b1;
            m_vld   = 1'b0;
            return;
        end
        if (redirect_valid) begin
            m_pend = 1'b1;
            m_ptgt = redirect_target;
        end
        case (m_phase)
            PH_BOOT: begin_fetch();
            PH_ASK:  if (imem_gnt) m_phase = PH_AWAIT;
            PH_AWAIT: begin
                if (imem_rvalid) begin
                    if (m_pend) begin
                        begin_fetch();
                    end else begin
                        m_vld   = 1'b1;
                        m_fresh = 1'b0;
                        m_ipc   = m_pc;
                        m_instr = imem_rdata;
                        m_ip4   = m_pc + 32'd4;
                        m_pc    = m_pc + 32'd4;
                        m_phase = PH_SHOW;
                    end
                end
            end
            PH_SHOW: begin
                if (m_pend || !stall) begin
                    m_vld = 1'b0;
                    begin_fetch();
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- per-cycle comparison ---------------------------------
    always @(posedge clk) begin
        model_step();
        #1;
        chk("imem_req", imem_req, (m_phase == PH_ASK));
        if (m_phase == PH_ASK || m_fresh) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", if_valid, m_vld);
        chk("misalign_err", misalign_err, m_err);
        if (m_vld || m_fresh) begin
            chk("if_pc", if_pc, m_ipc);
            chk("if_instr", if_instr, m_instr);
            chk("if_pcplus4", if_pcplus4, m_ip4);
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!if_valid && n < 40);
        if (!if_valid) timeout_fail(name);
    endtask

    task automatic wait_req(input string name, output int n);
        n = 0;
        while (!imem_req && n < 40) begin
            tick(1);
            n++;
        end
        if (!imem_req) timeout_fail(name);
    endtask

    task automatic do_reset();
        stall = 0;
        redirect_valid = 0;
        rst_n = 0;
        tick(2);
        rst_n = 1;
    endtask

    initial begin
        int n;
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] t;

        // reset values
        tick(3);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        rst_n = 1;

        // sequential fetch from 0
        wait_valid("seq0", n);
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_instr", if_instr, 32'h0010_0093);
        chk("seq0_pc4", if_pcplus4, 32'h4);
        wait_valid("seq1", n);
        chk("seq1_gap", n, 3);
        chk("seq1_pc", if_pc, 32'h4);
        chk("seq1_instr", if_instr, 32'h0020_0093);
        wait_valid("seq2", n);
        chk("seq2_gap", n, 3);
        chk("seq2_pc4", if_pcplus4, 32'hC);
        chk("seq2_instr", if_instr, 32'h0030_0093);

        // stall in HOLD for 5 cycles
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_valid", if_valid, 1'b1);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_req", imem_req, 1'b0);
        end
        stall = 0;
        wait_valid("after_stall", n);
        chk("after_stall_pc", if_pc, 32'hC);

        // redirect in WAIT coinciding with rvalid
        tick(1);
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h10);
        tick(1);
        redirect_valid = 1;
        redirect_target = 32'h200;
        tick(1);
        redirect_valid = 0;
        chk("t4_dropped", if_valid, 1'b0);
        chk("t4_newaddr", imem_addr, 32'h200);
        wait_valid("t4_valid", n);
        chk("t4_if_pc", if_pc, 32'h200);

        // wrap with delayed grant
        hold_cfg = 4;
        redirect_valid = 1;
        redirect_target = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_req_held", imem_req, 1'b1);
            chk("t6_addr_held", imem_addr, 32'hFFFF_FFFC);
            tick(1);
        end
        hold_cfg = 0;
        wait_valid("t6_valid", n);
        chk("t6_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("t6_pc4", if_pcplus4, 32'h0);
        wait_req("t6_next", n);
        chk("t6_next_addr", imem_addr, 32'h0);

        // misaligned redirect halts fetch
        redirect_valid = 1;
        redirect_target = 32'h102;
        tick(1);
        redirect_valid = 0;
        chk("t5_err", misalign_err, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t5_no_req", imem_req, 1'b0);
        end
        chk("t5_sticky", misalign_err, 1'b1);

        // reset mid-WAIT
        do_reset();
        wait_valid("t1_v0", n);
        wait_valid("t1_v1", n);
        chk("t1_pre_pc", if_pc, 32'h4);
        tick(2);
        rst_n = 0;
        #1;
        chk("t1_valid", if_valid, 1'b0);
        chk("t1_req", imem_req, 1'b0);
        chk("t1_addr", imem_addr, RST_PC);
        chk("t1_if_pc", if_pc, 32'h0);
        chk("t1_instr", if_instr, NOP);
        chk("t1_pc4", if_pcplus4, 32'h0);
        chk("t1_err", misalign_err, 1'b0);
        tick(2);
        rst_n = 1;
        chk("t1_idle_noreq", imem_req, 1'b0);
        tick(1);
        wait_req("t1_first_req", n);
        chk("t1_first_addr", imem_addr, RST_PC);

        // randomized traffic
        gnt_pct = 60;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 800; c++) begin
                stall = ($urandom_range(0, 99) < 30);
                redirect_valid = ($urandom_range(0, 99) < 6);
                t = $urandom();
                t[1:0] = ($urandom_range(0, 999) == 0) ? 2'b10 : 2'b00;
                if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
                redirect_target = t;
                tick(1);
            end
        end
        stall = 0;
        redirect_valid = 0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
